// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD-to-binary converter: FSM state encoding and
// iteration-count helpers derived from the digit count.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DIGITS_DEF = 4;
  localparam int ITER       = 4 * DIGITS_DEF;
  localparam int CNT_W      = $clog2(ITER);

  // One shift per bit of the packed BCD operand.
  function automatic int iter_of(input int digits);
    return 4 * digits;
  endfunction

  function automatic int cnt_w_of(input int digits);
    return (4 * digits > 1) ? $clog2(4 * digits) : 1;
  endfunction

endpackage

// File: rtl/bcd_sub3.sv
// Combinational nibble corrector for reverse double-dabble: digits that are
// 8 or greater after a right shift lose 3, anything else passes through.
module bcd_sub3 (
  input  logic [3:0] d,
  output logic [3:0] q
);

  assign q = (d >= 4'd8) ? d - 4'd3 : d;

endmodule

// File: rtl/bcd_to_bin.sv
// Sequential BCD-to-binary converter (reverse double-dabble, one bit per cycle)
// with valid/ready on both sides. Define BCD_CHECK_EN to flag nibbles above 9 on err.
module bcd_to_bin
  import bcd_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEF,
  parameter int BIN_W  = 14
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*DIGITS-1:0] bcd_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BIN_W-1:0]    bin_out,
  output logic                ovf,
  output logic                err
);

  localparam int N  = iter_of(DIGITS);
  localparam int CW = cnt_w_of(DIGITS);

  state_t           state_q, state_d;
  logic [N-1:0]     bcd_q, bin_q;
  logic [CW-1:0]    cnt_q;
  logic [BIN_W-1:0] bin_out_q;
  logic             ovf_q;

  logic [2*N-1:0]   shifted;
  logic [N-1:0]     bcd_sh, bin_sh, bcd_fix;
  logic [BIN_W-1:0] res_bin;
  logic             res_ovf;
  logic             accept;

  assign accept = in_valid && (state_q == IDLE);

  // The bcd LSB falls into the bin MSB on every shift.
  assign shifted = {bcd_q, bin_q} >> 1;
  assign bcd_sh  = shifted[2*N-1:N];
  assign bin_sh  = shifted[N-1:0];

  for (genvar g = 0; g < DIGITS; g++) begin : g_fix
    bcd_sub3 u_fix (
      .d (bcd_sh[4*g +: 4]),
      .q (bcd_fix[4*g +: 4])
    );
  end

  if (BIN_W < N) begin : g_narrow
    assign res_bin = bin_sh[BIN_W-1:0];
    assign res_ovf = |bin_sh[N-1:BIN_W];
  end else begin : g_wide
    assign res_bin = BIN_W'(bin_sh);
    assign res_ovf = 1'b0;
  end

  // NOTE: next-state gets its default before the case so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)    state_d = SHIFT;
      SHIFT:   if (cnt_q == '0) state_d = DONE;
      DONE:    if (out_ready)   state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bcd_q     <= '0;
      bin_q     <= '0;
      cnt_q     <= '0;
      bin_out_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            bcd_q <= bcd_in;
            bin_q <= '0;
            cnt_q <= CW'(N - 1);
          end
        end
        SHIFT: begin
          bcd_q <= bcd_fix;
          bin_q <= bin_sh;
          if (cnt_q == '0) begin
            bin_out_q <= res_bin;
            ovf_q     <= res_ovf;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef BCD_CHECK_EN
  logic bad_nib, err_q;

  always_comb begin
    bad_nib = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_in[4*i +: 4] > 4'd9) bad_nib = 1'b1;
    end
  end

  // Captured with the operand; held until the next accept.
  always_ff @(posedge clk) begin
    if (!rst_n)      err_q <= 1'b0;
    else if (accept) err_q <= bad_nib;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign bin_out   = bin_out_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_bcd_to_bin.sv
// Self-checking bench for bcd_to_bin: decimal-arithmetic reference model checked
// every cycle against a 14-bit and an 8-bit instance, plus directed literal checks.
module tb_bcd_to_bin;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] bcd_in;

  logic        in_ready, out_valid, ovf, err;
  logic [13:0] bin_out;
  logic        in_ready8, out_valid8, ovf8, err8;
  logic [7:0]  bin_out8;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  bcd_to_bin #(.DIGITS(4), .BIN_W(14)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bcd_in    (bcd_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bin_out   (bin_out),
    .ovf       (ovf),
    .err       (err)
  );

  bcd_to_bin #(.DIGITS(4), .BIN_W(8)) u_dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready8),
    .bcd_in    (bcd_in),
    .out_valid (out_valid8),
    .out_ready (out_ready),
    .bin_out   (bin_out8),
    .ovf       (ovf8),
    .err       (err8)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                              name, act, act, exp, exp, $time);
    else n_pass++;
  endtask

  function automatic int bcd_value(input logic [15:0] v);
    int acc = 0;
    int w   = 1;
    for (int i = 0; i < 4; i++) begin
      acc += int'(v[4*i +: 4]) * w;
      w   *= 10;
    end
    return acc;
  endfunction

  function automatic bit has_bad(input logic [15:0] v);
    for (int i = 0; i < 4; i++) if (v[4*i +: 4] > 4'd9) return 1'b1;
    return 1'b0;
  endfunction

  // Reference model: result due 16 edges after accept, released by out_ready.
  bit m_busy = 1'b0, m_done = 1'b0, m_bad = 1'b0;
  int m_left = 0, m_val = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
    end else if (m_done) begin
      if (out_ready) m_done <= 1'b0;
    end else if (m_busy) begin
      if (m_left == 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
      end
      m_left <= m_left - 1;
    end else if (in_valid) begin
      m_busy <= 1'b1;
      m_left <= 16;
      m_val  <= bcd_value(bcd_in);
      m_bad  <= has_bad(bcd_in);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready",   in_ready,   !(m_busy || m_done));
      check("out_valid",  out_valid,  m_done);
      check("in_ready8",  in_ready8,  !(m_busy || m_done));
      check("out_valid8", out_valid8, m_done);
      if (m_done) begin
        if (!m_bad) begin
          check("bin_out",  bin_out,  32'(m_val % 16384));
          check("ovf",      ovf,      m_val >= 16384);
          check("bin_out8", bin_out8, 32'(m_val % 256));
          check("ovf8",     ovf8,     m_val >= 256);
        end
`ifdef BCD_CHECK_EN
        check("err",  err,  m_bad);
        check("err8", err8, m_bad);
`else
        check("err",  err,  0);
        check("err8", err8, 0);
`endif
      end
    end
  end

  task automatic convert(input logic [15:0] v, input int hold,
                         output logic [13:0] b, output logic o, output logic e,
                         output logic [7:0] b8, output logic o8);
    int guard = 0;
    int lat   = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("idle_before_send", in_ready, 1);
    in_valid  = 1'b1;
    bcd_in    = v;
    out_ready = (hold == 0);
    @(posedge clk);
    #1;
    in_valid = (hold > 0);
    bcd_in   = 16'hFFFF;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!out_valid && lat < 40);
    check("latency", lat, 16);
    b  = bin_out;
    o  = ovf;
    e  = err;
    b8 = bin_out8;
    o8 = ovf8;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_out_valid", out_valid, 1);
      check("hold_in_ready",  in_ready,  0);
    end
    if (hold > 0) begin
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(negedge clk);
    check("ready_after_result", in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish before %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    logic [13:0] b;
    logic        o, e, o8, seen;
    logic [7:0]  b8;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    bcd_in    = 16'h0000;

    check("model_1234", bcd_value(16'h1234), 1234);
    check("model_9999", bcd_value(16'h9999), 9999);
    check("model_bad",  has_bad(16'h12A4),   1);

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready",  in_ready,  1);
    check("rst_out_valid", out_valid, 0);
    check("rst_bin_out",   bin_out,   0);
    check("rst_ovf",       ovf,       0);
    check("rst_err",       err,       0);
    check("rst_bin_out8",  bin_out8,  0);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    chk_en = 1'b1;

    convert(16'h0000, 0, b, o, e, b8, o8);
    check("zero_bin", b, 0);
    check("zero_ovf", o, 0);
    check("zero_err", e, 0);

    convert(16'h1234, 0, b, o, e, b8, o8);
    check("v1234_bin", b, 14'h04D2);
    check("v1234_ovf", o, 0);

    convert(16'h9999, 0, b, o, e, b8, o8);
    check("v9999_bin",  b,  14'h270F);
    check("v9999_ovf",  o,  0);
    check("v9999_bin8", b8, 15);
    check("v9999_ovf8", o8, 1);

    convert(16'h0042, 5, b, o, e, b8, o8);
    check("v42_bin", b, 42);

    convert(16'h12A4, 0, b, o, e, b8, o8);
`ifdef BCD_CHECK_EN
    check("bad_nibble_err", e, 1);
`else
    check("bad_nibble_err", e, 0);
`endif

    // Reset in the middle of a conversion: that operand must never complete.
    in_valid = 1'b1;
    bcd_in   = 16'h0777;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen  = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("no_result_after_reset", seen, 0);
    check("bin_cleared_by_reset", bin_out, 0);

    convert(16'h0507, 0, b, o, e, b8, o8);
    check("v507_bin", b, 507);

    convert(16'h0300, 0, b, o, e, b8, o8);
    check("v300_bin",  b,  300);
    check("v300_ovf",  o,  0);
    check("v300_bin8", b8, 44);
    check("v300_ovf8", o8, 1);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bcd_to_bin.md
Name: bcd_to_bin

Overview:
Sequential BCD-to-binary converter using reverse double-dabble: shift right one bit per cycle, then subtract 3 from every BCD digit that is 8 or greater. It is the inverse of the existing binary-to-BCD path, used where decimal keypad or display values must be returned to binary for arithmetic. It uses a valid/ready handshake on both sides and converts one operand at a time.

Parameters:
DIGITS, 4, number of packed BCD digits on the input (4 bits each, digit 0 in bits [3:0]).
BIN_W, 14, output binary width; must satisfy 2^BIN_W > 10^DIGITS-1 for ovf to stay 0 on valid input.

Ports:
clk  input  1  single system clock; all logic is on the rising edge.
rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
in_valid  input  1  bcd_in holds an operand.
in_ready  output  1  block can accept an operand.
bcd_in  input  4*DIGITS  packed BCD operand.
out_valid  output  1  bin_out, ovf and err are valid.
out_ready  input  1  consumer accepts the result.
bin_out  output  BIN_W  binary result.
ovf  output  1  result does not fit in BIN_W bits.
err  output  1  the operand contained a nibble greater than 9 (only when BCD_CHECK_EN is defined).

Behaviour:
- Reset (rst_n low at a rising clk edge) forces state IDLE, in_ready=1, out_valid=0, bin_out=0, ovf=0, err=0, and clears the iteration counter.
- Reset applies in every state, including mid-SHIFT and DONE; the in-flight operand is discarded and no result is produced.
- State IDLE: in_ready=1. When in_valid && in_ready at an edge:
  - load bcd_in into the bcd shift register and clear the binary shift register (4*DIGITS wide);
  - load cnt=4*DIGITS-1;
  - move to SHIFT.
- State SHIFT: in_ready=0. Each edge:
  - shift the combined {bcd, bin} register right by 1, so bcd LSB becomes bin MSB;
  - then correct each post-shift bcd nibble: subtract 3 when it is 8 or greater, else leave it unchanged.
  - When cnt==0, go to DONE and register the results: bin_out = low BIN_W bits of the final bin register; ovf = OR of its bits above BIN_W (0 when BIN_W >= 4*DIGITS). Otherwise decrement cnt.
- State DONE: out_valid=1; bin_out, ovf and err are held stable. On out_ready, drop out_valid and return to IDLE.
- in_ready stays 0 in DONE; there is no overlap between consecutive operands.
- Latency: out_valid rises 4*DIGITS edges after the accept edge (16 for the defaults). Minimum throughput is one operand per 4*DIGITS+2 cycles with out_ready held high.
- in_valid asserted outside IDLE is ignored. bcd_in is sampled only at the accept edge.
- Outputs are registered; no combinational path from inputs to outputs except none (in_ready and out_valid are decoded from state registers).

Optional Feature:
Macro BCD_CHECK_EN.
- Defined: at the accept edge, err is registered as the OR over all nibbles of (nibble > 9). err is presented with out_valid. The conversion still runs; bin_out is deterministic but not meaningful when err=1.
- Undefined: err is tied to 0, no checking logic is generated, and invalid nibbles produce a deterministic, unspecified bin_out.

Decomposition:
- Shared package bcd_pkg holds:
  - state encoding IDLE=2'd0, SHIFT=2'd1, DONE=2'd2;
  - the iteration-count constant ITER=4*DIGITS;
  - the counter width $clog2(ITER).
- One natural sub-module, bcd_sub3: a combinational 4-bit nibble corrector (input 8..15 gives input-3, otherwise passthrough). It is instantiated DIGITS times in a generate loop.

Test Plan:
- Reset, then bcd_in=16'h0000 with in_valid and out_ready held high -> after 16 edges out_valid=1, bin_out=0, ovf=0, err=0; in_ready returns to 1 the following cycle.
- bcd_in=16'h1234 -> bin_out=14'd1234 (0x04D2); bcd_in=16'h9999 -> bin_out=14'd9999 (0x270F); ovf=0 for both.
- Back-pressure: convert 16'h0042, hold out_ready=0 for 5 cycles -> out_valid and bin_out=42 stay stable and in_ready=0 with in_valid high; out_ready=1 -> back to IDLE.
- BCD_CHECK_EN defined: bcd_in=16'h12A4 -> err=1 alongside out_valid. Undefined: same stimulus -> err=0.
- Assert rst_n=0 for one edge at cycle 7 of SHIFT -> out_valid never rises for that operand; next operand 16'h0507 converts to 507.
- DIGITS=4, BIN_W=8, bcd_in=16'h0300 -> ovf=1, bin_out=300 mod 256=44.
